nn_neuron_sequencer: RTL and testbench
======================================

# nn_neuron_sequencer

Instruction-issue sequencer for the neural-network CPU: the encode side of the opcode decoder. It accepts one neuron command (input count, last-neuron flag) and emits the corresponding 16-bit instruction stream. The stream clears the accumulator, loads and MACs each input/weight pair, applies the SINN activation, stores the result and advances the pointers. Instructions leave on a valid/ready handshake into the fetch/decode path; a HALT is appended after the last neuron.

## Interface
- LOAD_NOPS, default 1: NOPs inserted between the weight LD and the MAC (legal range 0..3).
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  neuron command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_n  in  8  number of input/weight pairs (0..255).
- cmd_last  in  1  append HALT after this neuron.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  downstream accepts instr this cycle.
- instr  out  16  instruction word {opcode[15:12], rd[11:8], rs[7:4], rt/imm[3:0]}.
- busy  out  1  a neuron is being emitted.
- halted  out  1  HALT accepted; sticky until reset.

## Operation
- Opcodes: NOP 0000, ADD 0001, MUL 0010, SINN 0011, MAC 0100, ADDI 1001, HALT 1011, LD 1110, ST 1111.
- Register convention: r0 reads as zero. r1 is the input pointer, r2 the weight pointer, r6 the output pointer, r3 the accumulator, r4/r5 the operands.
- Operand semantics: LD rd = mem[rs+rt]. ST writes rd to mem[rs+rt]. ADDI rd = rs + imm4.
- Pointer initial values are set by software; the sequencer only increments them.
- FSM states: IDLE, CLR, LDX, LDW, NOP, MAC, INCX, INCW, ACT, STO, INCO, HALT, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, capture cmd_n into an 8-bit remaining counter, capture cmd_last, then go to CLR.
- CLR emits ADD r3,r0,r0 (16'h1300). Next state is LDX if remaining≠0, else ACT.
- Per-pair loop:
  - LDX emits E410 (LD r4,r1,r0).
  - LDW emits E520 (LD r5,r2,r0).
  - LOAD_NOPS × NOP 0000, using a 2-bit NOP counter. The NOP state is skipped when LOAD_NOPS=0.
  - MAC emits 4345 (MAC r3,r4,r5).
  - INCX emits 9111 (ADDI r1,r1,1).
  - INCW emits 9221 (ADDI r2,r2,1). remaining decrements on acceptance; next state is LDX if the new remaining≠0, else ACT.
- Epilogue:
  - ACT emits 3330 (SINN r3,r3,r0).
  - STO emits F360 (ST r3,r6,r0).
  - INCO emits 9661 (ADDI r6,r6,1). Next state is HALT if the captured last flag is set, else IDLE.
- HALT emits B000. On acceptance go to DONE.
- DONE: halted=1, cmd_ready=0, instr_valid=0. Held until reset.
- State advances only on instr_valid&instr_ready. No state skips or repeats under stall.
- Stream length per neuron: 4 + N·(5+LOAD_NOPS), plus 1 if last.
- Commands are ignored (cmd_ready=0) outside IDLE.

## Timing
- Reset (asynchronous, immediate): state=IDLE, counters=0, instr_valid=0, instr=16'h0000, cmd_ready=1, busy=0, halted=0.
- Reset asserted mid-stream aborts the neuron with no partial completion. The next command restarts with CLR.
- Command accepted at edge T: first instruction (1300) is valid in cycle T+1.
- instr_valid stays high continuously through the stream. With instr_ready held at 1, one instruction is issued per cycle with zero bubbles.
- After INCO is accepted at edge E (non-last neuron): instr_valid=0 and cmd_ready=1 in cycle E+1. There is one idle cycle between neurons.
- Stall rule: while instr_valid=1 and instr_ready=0, instr and instr_valid must stay stable.
- instr is registered (Moore). Neither instr nor cmd_ready has a combinational path from instr_ready or cmd_valid.
- busy=1 from T+1 until the last instruction of the neuron is accepted.
- halted rises the cycle after HALT is accepted.
- cmd_n=0 is legal: emit CLR, then go straight to ACT/STO/INCO.
- cmd_n=255 must complete without counter wrap.

## Test plan
- Reset: hold reset_n=0 → instr_valid=0, instr=0000, cmd_ready=1, busy=0, halted=0. Then drive reset_n low asynchronously mid-clock → outputs return to reset values before the next edge.
- N=1, last=0, LOAD_NOPS=1, instr_ready=1 → exactly 1300,E410,E520,0000,4345,9111,9221,3330,F360,9661 in 10 consecutive cycles. Then cmd_ready=1 and busy=0.
- N=0, last=1 → 1300,3330,F360,9661,B000. Then halted=1, and cmd_ready stays 0 for 20 cycles despite cmd_valid=1.
- N=3, LOAD_NOPS=0, last=0 → 19 instructions: the loop body E410,E520,4345,9111,9221 appears three times with no 0000.
- N=2 with random instr_ready (≈50%) → same 16-instruction sequence as with ready=1. instr is stable on every stalled cycle, and no duplicates or drops occur.
- Reset mid-stream after 3 accepted instructions of an N=4 neuron, then a new N=1 command → stream restarts at 1300, and the full N=1 sequence appears with no leftover loop iterations.

Source files
------------

// File: rtl/nn_neuron_sequencer.sv
// nn_neuron_sequencer: turns one neuron command into its CLR/LD/MAC/SINN/ST instruction stream
module nn_neuron_sequencer #(
  parameter int LOAD_NOPS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_n,
  input  logic        cmd_last,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic        busy,
  output logic        halted
);
  typedef enum logic [3:0] {
    IDLE, CLR, LDX, LDW, NOP, MAC, INCX, INCW, ACT, STO, INCO, HALT, DONE
  } state_t;
  localparam logic [1:0] nop_last = 2'(LOAD_NOPS - 1);
  state_t state, state_nx;
  logic [7:0] rem;
  logic [1:0] nop_cnt;
  logic last_q;
  logic fire, cmd_fire;
  logic [15:0] instr_nx;
  logic valid_nx, busy_nx;
  assign fire = instr_valid & instr_ready;
  assign cmd_fire = cmd_valid & cmd_ready;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = cmd_fire ? CLR : IDLE;
      CLR:  if (fire) state_nx = (rem != 8'd0) ? LDX : ACT;
      LDX:  if (fire) state_nx = LDW;
      LDW:  if (fire) state_nx = (LOAD_NOPS == 0) ? MAC : NOP;
      NOP:  if (fire && nop_cnt == nop_last) state_nx = MAC;
      MAC:  if (fire) state_nx = INCX;
      INCX: if (fire) state_nx = INCW;
      INCW: if (fire) state_nx = (rem == 8'd1) ? ACT : LDX;
      ACT:  if (fire) state_nx = STO;
      STO:  if (fire) state_nx = INCO;
      INCO: if (fire) state_nx = last_q ? HALT : IDLE;
      HALT: if (fire) state_nx = DONE;
      DONE: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // Outputs are decoded from the next state and registered, so they are Moore and glitch-free
  always_comb begin
    instr_nx = 16'h0000;
    case (state_nx)
      CLR:  instr_nx = 16'h1300;
      LDX:  instr_nx = 16'hE410;
      LDW:  instr_nx = 16'hE520;
      MAC:  instr_nx = 16'h4345;
      INCX: instr_nx = 16'h9111;
      INCW: instr_nx = 16'h9221;
      ACT:  instr_nx = 16'h3330;
      STO:  instr_nx = 16'hF360;
      INCO: instr_nx = 16'h9661;
      HALT: instr_nx = 16'hB000;
      default: instr_nx = 16'h0000;
    endcase
    valid_nx = (state_nx != IDLE) && (state_nx != DONE);
    busy_nx = valid_nx && (state_nx != HALT);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      instr <= 16'h0000;
      instr_valid <= 1'b0;
      cmd_ready <= 1'b1;
      busy <= 1'b0;
      halted <= 1'b0;
    end else begin
      instr <= instr_nx;
      instr_valid <= valid_nx;
      cmd_ready <= state_nx == IDLE;
      busy <= busy_nx;
      halted <= state_nx == DONE;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rem <= 8'd0;
      nop_cnt <= 2'd0;
      last_q <= 1'b0;
    end else begin
      if (cmd_fire) begin
        rem <= cmd_n;
        last_q <= cmd_last;
      end else if (state == INCW && fire) rem <= rem - 8'd1;
      nop_cnt <= (state == NOP && fire) ? nop_cnt + 2'd1 : 2'd0;
    end
endmodule

// File: tb/tb_nn_neuron_sequencer.sv
// tb_nn_neuron_sequencer: directed checks of the neuron instruction stream, stalls, reset and halt
module tb_nn_neuron_sequencer;
  logic clk = 0, reset_n = 0, cmd_valid0 = 0, cmd_valid1 = 0, cmd_last = 0, instr_ready = 1;
  logic [7:0] cmd_n = 0;
  logic cmd_ready0, instr_valid0, busy0, halted0;
  logic cmd_ready1, instr_valid1, busy1, halted1;
  logic [15:0] instr0, instr1;
  int total = 0, bad = 0;
  logic [15:0] exp_q[$], got_q[$];
  always #5 clk = ~clk;
  nn_neuron_sequencer #(.LOAD_NOPS(1)) u0 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_n(cmd_n), .cmd_last(cmd_last), .instr_valid(instr_valid0), .instr_ready(instr_ready),
    .instr(instr0), .busy(busy0), .halted(halted0)
  );
  nn_neuron_sequencer #(.LOAD_NOPS(0)) u1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_n(cmd_n), .cmd_last(cmd_last), .instr_valid(instr_valid1), .instr_ready(instr_ready),
    .instr(instr1), .busy(busy1), .halted(halted1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic build(input int n, input int nops, input bit last);
    exp_q.delete();
    exp_q.push_back(16'h1300);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(16'hE410);
      exp_q.push_back(16'hE520);
      for (int j = 0; j < nops; j++) exp_q.push_back(16'h0000);
      exp_q.push_back(16'h4345);
      exp_q.push_back(16'h9111);
      exp_q.push_back(16'h9221);
    end
    exp_q.push_back(16'h3330);
    exp_q.push_back(16'hF360);
    exp_q.push_back(16'h9661);
    if (last) exp_q.push_back(16'hB000);
  endtask
  task automatic run(input bit sel, input logic [7:0] n, input bit last, input bit rnd, input string tag);
    int cyc;
    logic v, pv, pr, r;
    logic [15:0] i, pi;
    got_q.delete();
    @(negedge clk);
    chk({tag, "_cmd_ready"}, sel ? cmd_ready1 : cmd_ready0, 1);
    cmd_n = n;
    cmd_last = last;
    if (sel) cmd_valid1 = 1; else cmd_valid0 = 1;
    cyc = 0; pv = 0; pr = 1; pi = 0;
    while (got_q.size() < exp_q.size() && cyc < 4000) begin
      @(negedge clk);
      cmd_valid0 = 0;
      cmd_valid1 = 0;
      cyc++;
      v = sel ? instr_valid1 : instr_valid0;
      i = sel ? instr1 : instr0;
      if (cyc == 1) begin
        chk({tag, "_first_valid"}, v, 1);
        chk({tag, "_first_busy"}, sel ? busy1 : busy0, 1);
      end
      if (pv && !pr) begin
        chk({tag, "_stall_valid"}, v, 1);
        chk({tag, "_stall_instr"}, i, pi);
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      instr_ready = r;
      if (v && r) got_q.push_back(i);
      pv = v; pi = i; pr = r;
    end
    instr_ready = 1;
    if (!rnd) chk({tag, "_cycles"}, cyc, exp_q.size());
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk($sformatf("%s_i%0d", tag, k), got_q[k], exp_q[k]);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int nops;
    repeat (2) @(negedge clk);
    chk("rst_valid", instr_valid0, 0);
    chk("rst_instr", instr0, 16'h0000);
    chk("rst_cmd_ready", cmd_ready0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_halted", halted0, 0);
    reset_n = 1;
    exp_q = '{16'h1300, 16'hE410, 16'hE520, 16'h0000, 16'h4345, 16'h9111, 16'h9221, 16'h3330, 16'hF360, 16'h9661};
    run(0, 8'd1, 0, 0, "n1");
    @(negedge clk);
    chk("n1_post_valid", instr_valid0, 0);
    chk("n1_post_cmd_ready", cmd_ready0, 1);
    chk("n1_post_busy", busy0, 0);
    build(3, 0, 0);
    run(1, 8'd3, 0, 0, "n3_nop0");
    nops = 0;
    foreach (got_q[k]) if (got_q[k] == 16'h0000) nops++;
    chk("n3_nop0_no_nops", nops, 0);
    chk("n3_nop0_count", got_q.size(), 19);
    build(2, 1, 0);
    run(0, 8'd2, 0, 1, "n2_rand");
    chk("n2_rand_count", got_q.size(), 16);
    build(255, 0, 0);
    run(1, 8'd255, 0, 0, "n255");
    @(negedge clk);
    chk("n255_post_cmd_ready", cmd_ready1, 1);
    cmd_n = 8'd4; cmd_last = 0; cmd_valid0 = 1; instr_ready = 1;
    @(posedge clk);
    #1 cmd_valid0 = 0;
    repeat (3) @(posedge clk);
    #1 chk("mid_busy", busy0, 1);
    chk("mid_instr", instr0, 16'h0000);
    #1 reset_n = 0;
    #1 chk("async_valid", instr_valid0, 0);
    chk("async_instr", instr0, 16'h0000);
    chk("async_cmd_ready", cmd_ready0, 1);
    chk("async_busy", busy0, 0);
    chk("async_halted", halted0, 0);
    @(negedge clk);
    reset_n = 1;
    exp_q = '{16'h1300, 16'hE410, 16'hE520, 16'h0000, 16'h4345, 16'h9111, 16'h9221, 16'h3330, 16'hF360, 16'h9661};
    run(0, 8'd1, 0, 0, "restart");
    exp_q = '{16'h1300, 16'h3330, 16'hF360, 16'h9661, 16'hB000};
    run(0, 8'd0, 1, 0, "n0_last");
    @(negedge clk);
    chk("done_halted", halted0, 1);
    chk("done_cmd_ready", cmd_ready0, 0);
    chk("done_valid", instr_valid0, 0);
    chk("done_busy", busy0, 0);
    cmd_valid0 = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("done_hold_ready%0d", k), cmd_ready0, 0);
      chk($sformatf("done_hold_valid%0d", k), instr_valid0, 0);
    end
    cmd_valid0 = 0;
    chk("done_still_halted", halted0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
